// File: rtl/udp_rx_word_packer.sv
// -----------------------------------------------------------------------------
// udp_rx_word_packer
//
// Packs the received UDP payload byte stream into WORD_BYTES-wide words and
// buffers them in a DEPTH-word FIFO for the reader. All logic runs in hclk.
// The rec_* inputs are expected to be synchronous to hclk already.
//
// Features: selectable byte order, partial-word flush at packet end (zero
// padded or discarded), sticky fill-level interrupt, sticky overflow flag and
// a per-packet count of words accepted into the FIFO.
//
// Ports
//   hclk                 in   clock, rising edge
//   sys_rst              in   synchronous reset, active high
//   rec_en / rec_data    in   payload byte strobe and byte
//   rec_pkt_done         in   packet end (may coincide with the last byte)
//   fifo_read            in   pop request
//   fifo_data_out        out  last popped word, held between pops
//   fifo_data_out_vaild  out  1-cycle strobe: fifo_data_out was updated
//   fifo_empty/full      out  FIFO level == 0 / == DEPTH
//   fifo_level           out  words stored
//   irq / irq_clr        out/in  threshold interrupt and its clear
//   overflow             out  sticky: a word was dropped on a full FIFO
//   pkt_words            out  words accepted for the last completed packet
//   pkt_done_pulse       out  1-cycle strobe when pkt_words updates
// -----------------------------------------------------------------------------
module udp_rx_word_packer #(
    parameter int WORD_BYTES  = 4,
    parameter int DEPTH       = 256,
    parameter int DEPTH_B     = 8,
    parameter int BIG_ENDIAN  = 1,
    parameter int PAD_PARTIAL = 1,
    parameter int THRESH      = 256
) (
    input  logic                      hclk,
    input  logic                      sys_rst,
    input  logic                      rec_en,
    input  logic [7:0]                rec_data,
    input  logic                      rec_pkt_done,
    input  logic                      fifo_read,
    output logic [8*WORD_BYTES-1:0]   fifo_data_out,
    output logic                      fifo_data_out_vaild,
    output logic                      fifo_empty,
    output logic                      fifo_full,
    output logic [DEPTH_B:0]          fifo_level,
    output logic                      irq,
    input  logic                      irq_clr,
    output logic                      overflow,
    output logic [15:0]               pkt_words,
    output logic                      pkt_done_pulse
);

    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    // ---------------- packer ----------------
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [DATA_W-1:0] pack_q, pack_d;
    logic [DATA_W-1:0] merged;
    logic              full_word, partial, push_req;

    // Each lane takes the incoming byte when the byte counter selects it.
    // In big-endian order byte 0 of the word lands in the top lane.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        localparam int LANE = (BIG_ENDIAN != 0) ? (WORD_BYTES - 1 - gi) : gi;
        assign merged[LANE*8 +: 8] = (rec_en && (bc_q == BC_W'(gi))) ? rec_data
                                                                     : pack_q[LANE*8 +: 8];
    end

    assign full_word = rec_en && (bc_q == BC_W'(WORD_BYTES - 1));
    // Partial word: bytes are pending (including one arriving now) but the
    // word is not complete at packet end.
    assign partial   = rec_pkt_done && !full_word && (rec_en || (bc_q != '0));
    assign push_req  = full_word || (partial && (PAD_PARTIAL != 0));

    always_comb begin
        bc_d   = bc_q;
        pack_d = merged;
        if (full_word || rec_pkt_done) begin
            // The pack register is cleared at word boundaries so unused lanes
            // of a padded partial word read as zero.
            bc_d   = '0;
            pack_d = '0;
        end else if (rec_en) begin
            bc_d = bc_q + BC_W'(1);
        end
    end

    // ---------------- FIFO ----------------
    logic [DEPTH_B:0]  wr_cnt_q, rd_cnt_q, level;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;
    logic              pop_acc, push_acc;

    assign level    = wr_cnt_q - rd_cnt_q;
    assign pop_acc  = fifo_read && (level != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_acc = push_req && ((level != (DEPTH_B+1)'(DEPTH)) || pop_acc);

    always_ff @(posedge hclk) begin
        if (push_acc) begin
            mem[wr_cnt_q[DEPTH_B-1:0]] <= merged;
        end
    end

    // ---------------- status / interrupt ----------------
    logic        ge_q, irq_q, ovf_q, pdp_q;
    logic [15:0] pkt_cnt_q, pkt_words_q;
    logic        ge;

    assign ge = (level >= (DEPTH_B+1)'(THRESH));

    always_ff @(posedge hclk) begin
        if (sys_rst) begin
            bc_q        <= '0;
            pack_q      <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            dout_q      <= '0;
            vld_q       <= 1'b0;
            ge_q        <= 1'b0;
            irq_q       <= 1'b0;
            ovf_q       <= 1'b0;
            pdp_q       <= 1'b0;
            pkt_cnt_q   <= '0;
            pkt_words_q <= '0;
        end else begin
            bc_q   <= bc_d;
            pack_q <= pack_d;
            vld_q  <= pop_acc;
            if (push_acc) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if (pop_acc) begin
                // Read-before-write: a same-cycle push to this slot (full
                // FIFO) lands after the old word has been captured.
                rd_cnt_q <= rd_cnt_q + 1'b1;
                dout_q   <= mem[rd_cnt_q[DEPTH_B-1:0]];
            end

            ge_q <= ge;
            if (irq_clr) begin
                irq_q <= 1'b0;
            end else if (ge && !ge_q) begin
                irq_q <= 1'b1;
            end
            if (irq_clr) begin
                ovf_q <= 1'b0;
            end else if (push_req && !push_acc) begin
                ovf_q <= 1'b1;
            end

            pdp_q <= rec_pkt_done;
            if (rec_pkt_done) begin
                pkt_words_q <= pkt_cnt_q + {15'd0, push_acc};
                pkt_cnt_q   <= '0;
            end else if (push_acc) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    assign fifo_data_out       = dout_q;
    assign fifo_data_out_vaild = vld_q;
    assign fifo_level          = level;
    assign fifo_empty          = (level == '0);
    assign fifo_full           = (level == (DEPTH_B+1)'(DEPTH));
    assign irq                 = irq_q;
    assign overflow            = ovf_q;
    assign pkt_words           = pkt_words_q;
    assign pkt_done_pulse      = pdp_q;

endmodule

// File: tb/tb_udp_rx_word_packer.sv
// -----------------------------------------------------------------------------
// Directed testbench for udp_rx_word_packer. Three instances share the clock
// and reset: 0 = big-endian with padding, 1 = little-endian with padding,
// 2 = big-endian with partial words discarded.
// -----------------------------------------------------------------------------
module tb_udp_rx_word_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_rst;
    logic        rec_en       [3];
    logic [7:0]  rec_data     [3];
    logic        rec_pkt_done [3];
    logic        fifo_read    [3];
    logic        irq_clr      [3];
    logic [31:0] dout         [3];
    logic        vld          [3];
    logic        emp          [3];
    logic        ful          [3];
    logic [8:0]  lvl          [3];
    logic        irq          [3];
    logic        ovf          [3];
    logic [15:0] pw           [3];
    logic        pdp          [3];

    int n_cmp  = 0;
    int n_fail = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        udp_rx_word_packer #(
            .WORD_BYTES (4),
            .DEPTH      (256),
            .DEPTH_B    (8),
            .BIG_ENDIAN ((gi == 1) ? 0 : 1),
            .PAD_PARTIAL((gi == 2) ? 0 : 1),
            .THRESH     (256)
        ) u_dut (
            .hclk               (clk),
            .sys_rst            (sys_rst),
            .rec_en             (rec_en[gi]),
            .rec_data           (rec_data[gi]),
            .rec_pkt_done       (rec_pkt_done[gi]),
            .fifo_read          (fifo_read[gi]),
            .fifo_data_out      (dout[gi]),
            .fifo_data_out_vaild(vld[gi]),
            .fifo_empty         (emp[gi]),
            .fifo_full          (ful[gi]),
            .fifo_level         (lvl[gi]),
            .irq                (irq[gi]),
            .irq_clr            (irq_clr[gi]),
            .overflow           (ovf[gi]),
            .pkt_words          (pw[gi]),
            .pkt_done_pulse     (pdp[gi])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] b, input logic done, input logic rd);
        rec_en[d]       = 1'b1;
        rec_data[d]     = b;
        rec_pkt_done[d] = done;
        fifo_read[d]    = rd;
        tick();
        rec_en[d]       = 1'b0;
        rec_pkt_done[d] = 1'b0;
        fifo_read[d]    = 1'b0;
    endtask

    task automatic pop(input int d);
        fifo_read[d] = 1'b1;
        tick();
        fifo_read[d] = 1'b0;
    endtask

    task automatic pkt_end(input int d);
        rec_pkt_done[d] = 1'b1;
        tick();
        rec_pkt_done[d] = 1'b0;
    endtask

    // Distinct word per index k; bytes sent MSB first so the big-endian
    // packer reassembles exactly this value.
    function automatic logic [31:0] exp_word(input int k);
        logic [15:0] kk;
        kk = 16'(k);
        return {kk[7:0], kk[15:8], 8'h5A, ~kk[7:0]};
    endfunction

    function automatic logic [7:0] wbyte(input int k, input int j);
        logic [31:0] w;
        w = exp_word(k);
        return w[31-8*j -: 8];
    endfunction

    task automatic send_word(input int d, input int k);
        for (int j = 0; j < 4; j++) send(d, wbyte(k, j), 1'b0, 1'b0);
    endtask

    initial begin
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rec_en[i] = 0; rec_data[i] = 0; rec_pkt_done[i] = 0;
            fifo_read[i] = 0; irq_clr[i] = 0;
        end
        tick(); tick();
        sys_rst = 1'b0;
        tick();

        // Reset state
        chk("rst_empty", emp[0], 1);
        chk("rst_full",  ful[0], 0);
        chk("rst_level", lvl[0], 0);
        chk("rst_dout",  dout[0], 0);
        chk("rst_vld",   vld[0], 0);
        chk("rst_irq",   irq[0], 0);
        chk("rst_ovf",   ovf[0], 0);
        chk("rst_pw",    pw[0], 0);
        chk("rst_pdp",   pdp[0], 0);
        $display("reset state checked");

        // 1: big-endian word
        send(0, 8'h11, 0, 0); send(0, 8'h22, 0, 0); send(0, 8'h33, 0, 0);
        chk("t1_level_before", lvl[0], 0);
        send(0, 8'h44, 0, 0);
        chk("t1_level", lvl[0], 1);
        chk("t1_empty", emp[0], 0);
        pop(0);
        $display("t1 pop dout=%08h vld=%0b", dout[0], vld[0]);
        chk("t1_vld",   vld[0], 1);
        chk("t1_dout",  dout[0], 32'h11223344);
        chk("t1_level0", lvl[0], 0);
        chk("t1_empty1", emp[0], 1);
        tick();
        chk("t1_vld_drop", vld[0], 0);
        chk("t1_dout_hold", dout[0], 32'h11223344);
        pkt_end(0);
        chk("t1_pdp", pdp[0], 1);
        chk("t1_pw",  pw[0], 1);
        tick();
        chk("t1_pdp_drop", pdp[0], 0);

        // 2: little-endian, padded partial word
        send(1, 8'h11, 0, 0); send(1, 8'h22, 0, 0); send(1, 8'h33, 0, 0);
        send(1, 8'h44, 1, 0);
        chk("t2_pdp_a", pdp[1], 1);
        chk("t2_pw_a",  pw[1], 1);
        pop(1);
        $display("t2 pop dout=%08h", dout[1]);
        chk("t2_le_word", dout[1], 32'h44332211);
        send(1, 8'hAA, 0, 0); send(1, 8'hBB, 0, 0); send(1, 8'hCC, 0, 0);
        send(1, 8'hDD, 0, 0); send(1, 8'hEE, 0, 0); send(1, 8'hFF, 1, 0);
        chk("t2_pdp_b", pdp[1], 1);
        chk("t2_pw_b",  pw[1], 2);
        chk("t2_level", lvl[1], 2);
        pop(1);
        $display("t2 pop dout=%08h", dout[1]);
        chk("t2_w0", dout[1], 32'hDDCCBBAA);
        pop(1);
        $display("t2 pop dout=%08h", dout[1]);
        chk("t2_w1_pad", dout[1], 32'h0000FFEE);
        chk("t2_level0", lvl[1], 0);

        // 3: partial word discarded
        send(2, 8'hAA, 0, 0); send(2, 8'hBB, 0, 0); send(2, 8'hCC, 0, 0);
        send(2, 8'hDD, 0, 0); send(2, 8'hEE, 0, 0); send(2, 8'hFF, 1, 0);
        chk("t3_pdp",   pdp[2], 1);
        chk("t3_pw",    pw[2], 1);
        chk("t3_level", lvl[2], 1);
        pop(2);
        $display("t3 pop dout=%08h", dout[2]);
        chk("t3_word",  dout[2], 32'hAABBCCDD);
        chk("t3_level0", lvl[2], 0);
        pkt_end(2);
        chk("t3_empty_pdp", pdp[2], 1);
        chk("t3_empty_pw",  pw[2], 0);

        // 4: fill to full, threshold interrupt, overflow
        for (int k = 0; k < 256; k++) send_word(0, k);
        $display("t4 filled level=%0d full=%0b irq=%0b", lvl[0], ful[0], irq[0]);
        chk("t4_level_full", lvl[0], 256);
        chk("t4_full",       ful[0], 1);
        chk("t4_irq_not_yet", irq[0], 0);
        send(0, wbyte(256, 0), 0, 0);
        chk("t4_irq_rise", irq[0], 1);
        chk("t4_ovf_not_yet", ovf[0], 0);
        send(0, wbyte(256, 1), 0, 0);
        send(0, wbyte(256, 2), 0, 0);
        send(0, wbyte(256, 3), 0, 0);
        chk("t4_ovf",       ovf[0], 1);
        chk("t4_level_256", lvl[0], 256);
        pkt_end(0);
        chk("t4_pw_accepted", pw[0], 256);
        irq_clr[0] = 1'b1;
        tick();
        irq_clr[0] = 1'b0;
        chk("t4_irq_clr", irq[0], 0);
        chk("t4_ovf_clr", ovf[0], 0);
        tick();
        chk("t4_irq_no_refire", irq[0], 0);

        // 5: full FIFO with simultaneous push and pop, then order across wrap
        send(0, wbyte(256, 0), 0, 0);
        send(0, wbyte(256, 1), 0, 0);
        send(0, wbyte(256, 2), 0, 0);
        send(0, wbyte(256, 3), 0, 1);
        $display("t5 push+pop level=%0d ovf=%0b dout=%08h", lvl[0], ovf[0], dout[0]);
        chk("t5_level", lvl[0], 256);
        chk("t5_ovf",   ovf[0], 0);
        chk("t5_vld",   vld[0], 1);
        chk("t5_first", dout[0], exp_word(0));
        for (int k = 1; k <= 256; k++) begin
            pop(0);
            chk($sformatf("t5_drain_%0d", k), dout[0], exp_word(k));
        end
        chk("t5_empty", emp[0], 1);
        for (int k = 257; k < 769; k++) begin
            send_word(0, k);
            pop(0);
            chk($sformatf("t5_wrap_%0d", k), dout[0], exp_word(k));
        end
        $display("t5 wrap stream done level=%0d", lvl[0]);

        // 6: reset mid-word
        send(0, 8'h01, 0, 0); send(0, 8'h02, 0, 0);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("t6_level", lvl[0], 0);
        chk("t6_empty", emp[0], 1);
        chk("t6_dout",  dout[0], 0);
        chk("t6_pw",    pw[0], 0);
        chk("t6_vld",   vld[0], 0);
        send(0, 8'h10, 0, 0); send(0, 8'h20, 0, 0);
        send(0, 8'h30, 0, 0); send(0, 8'h40, 0, 0);
        chk("t6_level1", lvl[0], 1);
        pop(0);
        $display("t6 pop dout=%08h", dout[0]);
        chk("t6_word", dout[0], 32'h10203040);
        tick();
        pop(0);
        chk("t6_empty_pop_vld",  vld[0], 0);
        chk("t6_empty_pop_hold", dout[0], 32'h10203040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
